// File: rtl/norm_unit.sv
// Multi-cycle normalizer: finds the leading-zero, trailing-zero or redundant-sign-bit count of an operand and shifts it out.
// Optional macro NORM_FAST_EN enables byte-skip stepping (8 positions per cycle when safe); results are unchanged.
module norm_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  NormFn,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] Norm_out,
    output logic [5:0]  Shift_amt,
    output logic        Zero
);

    // state | meaning
    // IDLE  | waiting for start; operand captured on accept
    // RUN   | one shift step per cycle until the termination condition holds
    // DONE  | one-cycle done pulse, results valid
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] FN_LZ  = 2'b00;
    localparam logic [1:0] FN_TZ  = 2'b01;
    localparam logic [1:0] FN_SGN = 2'b10;

    state_t      state, state_nx;
    logic [31:0] w;
    logic [5:0]  c;
    logic [1:0]  fn;
    logic        zero_flag;

    logic        load;
    logic        step;
    logic        finish;
    logic        term;
    logic        skip;

    always_comb begin
        term = 1'b1;
        case (fn)
            FN_LZ:   term = w[31] || (c == 6'd32);
            FN_TZ:   term = w[0] || (c == 6'd32);
            FN_SGN:  term = (w[31] != w[30]) || (c == 6'd31);
            default: term = 1'b1;
        endcase
    end

`ifdef NORM_FAST_EN
    // A byte step is only taken when it cannot overshoot the final count.
    always_comb begin
        skip = 1'b0;
        case (fn)
            FN_LZ:   skip = (w[31:24] == 8'h00) && (c <= 6'd24);
            FN_TZ:   skip = (w[7:0] == 8'h00) && (c <= 6'd24);
            FN_SGN:  skip = ((w[31:23] == 9'h000) || (w[31:23] == 9'h1FF)) && (c <= 6'd23);
            default: skip = 1'b0;
        endcase
    end
`else
    always_comb begin
        skip = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (term) begin
                    finish   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w         <= '0;
            c         <= '0;
            fn        <= '0;
            zero_flag <= 1'b0;
            Norm_out  <= '0;
            Shift_amt <= '0;
            Zero      <= 1'b0;
        end else begin
            if (load) begin
                w         <= x;
                fn        <= NormFn;
                c         <= '0;
                zero_flag <= (x == 32'd0);
            end else if (step) begin
                if (skip) begin
                    w <= (fn == FN_TZ) ? (w >> 8) : (w << 8);
                    c <= c + 6'd8;
                end else begin
                    w <= (fn == FN_TZ) ? (w >> 1) : (w << 1);
                    c <= c + 6'd1;
                end
            end
            if (finish) begin
                Norm_out  <= w;
                Shift_amt <= c;
                Zero      <= zero_flag;
            end
        end
    end

endmodule

// File: tb/tb_norm_unit.sv
// Directed self-checking bench for norm_unit; latency expectations follow NORM_FAST_EN when defined.
module tb_norm_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  NormFn;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] Norm_out;
    logic [5:0]  Shift_amt;
    logic        Zero;

    int errors = 0;
    int checks = 0;
    int lat;
    bit seen;

    norm_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .NormFn    (NormFn),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .Norm_out  (Norm_out),
        .Shift_amt (Shift_amt),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one operation from a negedge and returns at the negedge where done is seen.
    // poke>0 drives a stray start with junk operands at that cycle while busy.
    task automatic do_op(input logic [1:0] f, input logic [31:0] xv, input int poke,
                         output int cycles, output bit got_done);
        cycles   = 0;
        got_done = 1'b0;
        start    = 1'b1;
        NormFn   = f;
        x        = xv;
        while (cycles < 80 && !got_done) begin
            @(negedge clk);
            cycles++;
            start = (cycles == poke);
            if (cycles == poke) begin
                x      = 32'hFFFF_FFFF;
                NormFn = 2'b01;
            end else begin
                x      = 32'hDEAD_BEEF;
                NormFn = 2'b11;
            end
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic chk_pulse_end(input string tag);
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        NormFn = 2'b00;
        x      = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_norm", Norm_out, 32'd0);
        chk("rst_shift", {26'd0, Shift_amt}, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);

        start = 1'b1;
        x     = 32'h0001_0000;
        repeat (2) @(negedge clk);
        chk("rst_held_start_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        do_op(2'b00, 32'h0001_0000, 0, lat, seen);
`ifdef NORM_FAST_EN
        chk("lz_lat", lat, 32'd10);
`else
        chk("lz_lat", lat, 32'd17);
`endif
        chk("lz_shift", {26'd0, Shift_amt}, 32'd15);
        chk("lz_norm", Norm_out, 32'h8000_0000);
        chk("lz_zero", {31'd0, Zero}, 32'd0);
        chk_pulse_end("lz");

        do_op(2'b01, 32'h0000_0A00, 0, lat, seen);
`ifdef NORM_FAST_EN
        chk("tz_lat", lat, 32'd4);
`else
        chk("tz_lat", lat, 32'd11);
`endif
        chk("tz_shift", {26'd0, Shift_amt}, 32'd9);
        chk("tz_norm", Norm_out, 32'h0000_0005);

        // Issued in the IDLE cycle right after done: back-to-back accept.
        @(negedge clk);
        do_op(2'b10, 32'hFFFF_8000, 0, lat, seen);
`ifdef NORM_FAST_EN
        chk("sgn_lat", lat, 32'd4);
`else
        chk("sgn_lat", lat, 32'd18);
`endif
        chk("sgn_shift", {26'd0, Shift_amt}, 32'd16);
        chk("sgn_norm", Norm_out, 32'h8000_0000);

        @(negedge clk);
        do_op(2'b00, 32'h0000_0000, 0, lat, seen);
`ifdef NORM_FAST_EN
        chk("lz0_lat", lat, 32'd6);
`else
        chk("lz0_lat", lat, 32'd34);
`endif
        chk("lz0_shift", {26'd0, Shift_amt}, 32'd32);
        chk("lz0_norm", Norm_out, 32'd0);
        chk("lz0_zero", {31'd0, Zero}, 32'd1);

        @(negedge clk);
        do_op(2'b01, 32'h0000_0000, 0, lat, seen);
        chk("tz0_seen", {31'd0, seen}, 32'd1);
        chk("tz0_shift", {26'd0, Shift_amt}, 32'd32);
        chk("tz0_zero", {31'd0, Zero}, 32'd1);

        @(negedge clk);
        do_op(2'b10, 32'hFFFF_FFFF, 0, lat, seen);
        chk("sgn1_seen", {31'd0, seen}, 32'd1);
        chk("sgn1_shift", {26'd0, Shift_amt}, 32'd31);
        chk("sgn1_norm", Norm_out, 32'h8000_0000);
        chk("sgn1_zero", {31'd0, Zero}, 32'd0);

        @(negedge clk);
        do_op(2'b10, 32'h0000_0000, 0, lat, seen);
        chk("sgn0_shift", {26'd0, Shift_amt}, 32'd31);
        chk("sgn0_norm", Norm_out, 32'd0);

        @(negedge clk);
        do_op(2'b11, 32'h1234_5678, 0, lat, seen);
        chk("rsv_lat", lat, 32'd2);
        chk("rsv_shift", {26'd0, Shift_amt}, 32'd0);
        chk("rsv_norm", Norm_out, 32'h1234_5678);
        chk_pulse_end("rsv");

        do_op(2'b00, 32'h0000_0001, 5, lat, seen);
`ifdef NORM_FAST_EN
        chk("busy_ign_lat", lat, 32'd12);
`else
        chk("busy_ign_lat", lat, 32'd33);
`endif
        chk("busy_ign_shift", {26'd0, Shift_amt}, 32'd31);
        chk("busy_ign_norm", Norm_out, 32'h8000_0000);
        chk_pulse_end("busy_ign");

        // Reset mid-RUN: must abort with no done pulse and cleared outputs.
        start  = 1'b1;
        NormFn = 2'b00;
        x      = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_norm", Norm_out, 32'd0);
        chk("mid_rst_shift", {26'd0, Shift_amt}, 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("mid_rst_no_done", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/norm_unit.md
# norm_unit

- Multi-cycle normalizer for the integer datapath; the inverse of the shift unit.
- Given an operand, it finds the shift amount that normalizes it: leading zeros, trailing zeros, or redundant sign bits.
- It returns the shifted operand together with that amount.
- It sits beside the ALU/shift unit as a start/done coprocessor and feeds the register-file write-back mux.

## Interface
Parameters: none (fixed 32-bit datapath).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- NormFn  input  2  00 left-normalize (count leading zeros), 01 right-normalize (count trailing zeros), 10 signed left-normalize (count redundant sign bits), 11 reserved
- x  input  32  operand, captured on the accepted start edge
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; results valid
- Norm_out  output  32  normalized operand
- Shift_amt  output  6  shift amount, range 0..32
- Zero  output  1  captured operand was 0

## Operation
- States:
  - IDLE: start=1 loads x into the working register W, NormFn into the fn register, and clears count C. Zero is set to (x==0). Go to RUN.
  - RUN: each cycle, evaluate the termination condition T on W and C.
    - If T holds: go to DONE.
    - Otherwise: shift W by 1 (left for 00/10, logical right for 01), C+=1, stay in RUN.
  - DONE: done=1 for exactly one cycle, then go to IDLE. A start in DONE is ignored.
- Termination condition T:
  - 00: W[31]==1 or C==32.
  - 01: W[0]==1 or C==32.
  - 10: W[31]!=W[30] or C==31.
  - 11: always true, so C=0 and Norm_out=x.
- Norm_out, Shift_amt and Zero are registered from W, C and the zero flag on the RUN→DONE transition. They hold until the next accepted start.
- Edge results:
  - x=0 with 00 or 01 yields Shift_amt=32, Norm_out=0.
  - x=0 or x=0xFFFFFFFF with 10 yields Shift_amt=31, Norm_out = x<<31.
- start while busy=1 is ignored; in-flight state is unaffected.
- busy=1 in RUN and DONE; busy=0 in IDLE.
- NormFn and x are don't-care except on the accepted start edge.

## Timing
- Reset (rst=1 at an edge, in any state, including mid-RUN): state=IDLE, busy=0, done=0, Norm_out=0, Shift_amt=0, Zero=0. Any in-flight operation is discarded with no done pulse.
- Latency without the fast path: a result needing k shifts spends k+1 cycles in RUN. done is high in the (k+2)th cycle after the accepted start edge, and outputs are valid in that same cycle.
- Worst case: k=32, giving done 34 cycles after start.
- Back-to-back: a new start is accepted in the IDLE cycle after done, so the minimum issue interval is k+3 cycles.

## Configuration
- NORM_FAST_EN defined: in RUN, a byte skip happens when both conditions below hold:
  - Skip condition:
    - 00: W[31:24]==0.
    - 01: W[7:0]==0.
    - 10: W[31:23] all equal.
  - Range condition: C+8 ≤ 32 for 00/01, C+8 ≤ 31 for 10.
- When the skip happens: W shifts by 8 and C+=8 in one cycle. Otherwise the single-bit rule applies.
- Results are identical to the base mode.
- RUN cycles = floor(k/8) + (k mod 8) + 1 for 00/01. For 10 the same count applies except when fewer bits remain than a full byte step permits.
- NORM_FAST_EN undefined: single-bit stepping only; latency as in Timing.

## Test plan
- Reset then idle → busy=0, done=0, Norm_out=0, Shift_amt=0, Zero=0; start with rst=1 held → no busy.
- NormFn=00, x=0x00010000 → Shift_amt=15, Norm_out=0x80000000, Zero=0, done exactly 17 cycles after start (base).
- NormFn=01, x=0x00000A00 → Shift_amt=9, Norm_out=0x00000005. Then NormFn=10, x=0xFFFF8000 → Shift_amt=16, Norm_out=0x80000000.
- NormFn=00, x=0 → Shift_amt=32, Norm_out=0, Zero=1. NormFn=11, x=0x12345678 → Shift_amt=0, Norm_out=0x12345678, done 2 cycles after start.
- Start pulsed with x=0xFFFFFFFF while busy on x=0x00000001/00 → ignored, result Shift_amt=31. A later op with rst=1 asserted mid-RUN → IDLE next cycle, no done, outputs 0.
- NORM_FAST_EN defined, NormFn=00, x=0x00000001 → Shift_amt=31, Norm_out=0x80000000, done 12 cycles after start (11 RUN cycles), versus 33 cycles without the macro.
